conv_pool_multi: RTL and testbench
==================================

Name: conv_pool_multi

Overview:
- Parametrised successor to the fixed three-kernel 4x4-tile conv/pool engine.
- Streams NUM_TILES 4x4 uint8 tiles from image memory and applies NUM_K signed 3x3 kernels, giving a 2x2 valid-conv map per kernel.
- Pools each map (max or average), applies ReLU, scales and saturates to uint8, and writes one byte per kernel per tile to result memories.
- Adds start/busy/done control, base-address offset, per-kernel write mask and pool-mode select.

Parameters:
- NUM_K, 3, number of kernels/output channels (1..8)
- ADDR_W, 16, tile address width for image and result memories
- SHIFT_W, 3, width of the output right-shift amount

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first tile address
- num_tiles  in  ADDR_W+1  tile count (0..2^ADDR_W)
- pool_mode  in  1  0 = max, 1 = average
- shift  in  SHIFT_W  right-shift applied after ReLU
- kernel_en  in  NUM_K  per-kernel write enable mask
- conv_kernels  in  NUM_K*72  kernel k at [72k+71:72k]; weight (i,j) int8 at bits [8(3i+j)+7:8(3i+j)]
- input_re  out  1  image memory read enable
- input_addr  out  ADDR_W  image read address
- image_4x4  in  128  tile data, valid the cycle after input_re; pixel (r,c) uint8 at [8(4r+c)+7:8(4r+c)]
- output_we  out  NUM_K  per-kernel result write enable
- output_addr  out  ADDR_W  shared result address (= tile address)
- y  out  NUM_K*8  result byte k at [8k+7:8k]
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release) values: input_re, input_addr, output_we, output_addr, y, busy, done = 0. FSM goes to IDLE and all pipeline valids clear.
- Reset mid-run aborts the run: no further reads or writes, and no done pulse.
- FSM states:
  - IDLE: on start with num_tiles>0, latch base_addr, num_tiles, pool_mode, shift, kernel_en and conv_kernels, then go to RUN. On start with num_tiles=0, go to DONE.
  - RUN: one read per cycle with input_addr = base_addr + n (mod 2^ADDR_W), n = 0..num_tiles-1. After the last read, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- start is ignored while busy. Latched configuration is stable for the whole run; port changes during a run have no effect.
- Timing: start sampled at edge 0 gives input_re high in cycle 1; if input_re is high in cycle t, data arrives in t+1 and output_we/output_addr/y are valid in cycle t+3. Throughput is 1 tile/cycle with no bubbles.
- output_addr equals the read address of the same tile.
- done asserts the cycle after the last output_we cycle. busy is high from cycle 1 through the done cycle.
- Arithmetic per kernel:
  - conv(a,b) = sum over i,j in 0..2 of pix(a+i,b+j) * w(i,j), for a,b in {0,1}; unsigned x signed, 21-bit signed accumulator, no overflow possible.
  - pool = max of the 4 values (signed), or floor(sum of the 4 >>> 2) with an arithmetic shift.
  - relu = max(pool,0); scaled = relu >> shift; y_k = min(scaled,255).
- output_we[k] = pipeline valid AND latched kernel_en[k]. y_k is computed regardless of the mask, and is held between writes.
- num_tiles = 2^ADDR_W: every address is read exactly once, and input_addr wraps at 2^ADDR_W-1 → 0.

Decomposition:
- Package conv_pool_pkg:
  - constants PIX_W=8, TILE_PIX=16, KER_TAPS=9, ACC_W=21
  - FSM enum {IDLE, RUN, DRAIN, DONE}
  - pool_mode_e {POOL_MAX, POOL_AVG}
- Sub-module conv_pool_lane: one per kernel, generate-instantiated NUM_K times. It holds the 2-stage multiply/accumulate → pool/ReLU/shift/saturate pipeline for one kernel.
- The top level holds the FSM, address counter and valid pipeline.

Test Plan:
- Identity kernel (only w(1,1)=0x01), all pixels 0x0A, max mode, shift 0, num_tiles=4, base 0 → four writes to addrs 0..3 with y=0x0A; output_we rises 3 cycles after the first input_re; done comes the cycle after the 4th write.
- All-ones kernel (every weight 0x01), pixels 200, avg mode, shift 3 → conv=1800, y=225 (0xE1). Same stimulus with shift 0 → y=0xFF (saturated).
- All -1 kernel (every weight 0xFF), pixels 50, NUM_K=3, kernel_en=3'b101 → y0=y2=0x00 written; output_we[1] never asserts.
- base_addr=0xFFFE, num_tiles=4 → input_addr sequence FFFE, FFFF, 0000, 0001; output_addr matches the same order.
- num_tiles=0 → done one cycle after the DONE transition; no input_re or output_we. A second start while busy during a 10-tile run is ignored, giving exactly 10 writes.
- rst asserted low mid-run (tile 5 of 10) → all outputs 0 immediately; no done. A new start after release runs cleanly from base_addr.

Source files
------------

// File: rtl/conv_pool_pkg.sv
// rtl/conv_pool_pkg.sv - shared constants, enums and conv helper for the conv/pool engine
package conv_pool_pkg;

    localparam int PIX_W    = 8;
    localparam int TILE_PIX = 16;
    localparam int KER_TAPS = 9;
    localparam int ACC_W    = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // One 3x3 valid-conv output at (a,b) of a 4x4 tile: unsigned pixels times
    // signed weights. Worst case 9*255*128 fits comfortably in ACC_W bits.
    function automatic logic signed [ACC_W-1:0] conv_at(
        input logic [TILE_PIX*PIX_W-1:0] tile,
        input logic [KER_TAPS*PIX_W-1:0] kern,
        input int                        a,
        input int                        b
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] p;
        logic signed [ACC_W-1:0] w;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p   = ACC_W'(tile[PIX_W*(4*(a+i)+(b+j)) +: PIX_W]);
                w   = ACC_W'($signed(kern[PIX_W*(3*i+j) +: PIX_W]));
                acc = acc + p * w;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/conv_pool_lane.sv
// rtl/conv_pool_lane.sv - per-kernel conv -> pool/ReLU/shift/saturate pipeline
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   s1_en      tile on the image bus is valid; capture the four conv sums
//   tile       4x4 uint8 tile
//   kern       nine int8 weights of this kernel
//   s2_en      conv sums are valid; update the result byte
//   pool_mode  0 = max, 1 = average
//   shift      right shift applied after ReLU
//   y          result byte, held until the next valid tile
module conv_pool_lane
    import conv_pool_pkg::*;
#(
    parameter int SHIFT_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s1_en,
    input  logic [TILE_PIX*PIX_W-1:0]   tile,
    input  logic [KER_TAPS*PIX_W-1:0]   kern,
    input  logic                        s2_en,
    input  logic                        pool_mode,
    input  logic [SHIFT_W-1:0]          shift,
    output logic [PIX_W-1:0]            y
);

    logic signed [ACC_W-1:0] conv_q [4];
    logic signed [ACC_W-1:0] max4;
    logic signed [ACC_W+1:0] sum4;
    logic signed [ACC_W+1:0] pool_v;
    logic        [ACC_W+1:0] relu_v;
    logic        [ACC_W+1:0] scaled_v;
    logic        [PIX_W-1:0] y_d;

    // Stage 1: map position o = 2a + b
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 4; o++) begin
                conv_q[o] <= '0;
            end
        end else if (s1_en) begin
            for (int o = 0; o < 4; o++) begin
                conv_q[o] <= conv_at(tile, kern, o / 2, o % 2);
            end
        end
    end

    always_comb begin
        max4 = conv_q[0];
        for (int o = 1; o < 4; o++) begin
            if (conv_q[o] > max4) begin
                max4 = conv_q[o];
            end
        end
        sum4 = (ACC_W+2)'(conv_q[0]) + (ACC_W+2)'(conv_q[1])
             + (ACC_W+2)'(conv_q[2]) + (ACC_W+2)'(conv_q[3]);
        // Arithmetic shift gives floor division for negative sums.
        pool_v   = (pool_mode == POOL_AVG) ? (sum4 >>> 2) : (ACC_W+2)'(max4);
        relu_v   = pool_v[ACC_W+1] ? '0 : $unsigned(pool_v);
        scaled_v = relu_v >> shift;
        y_d      = (scaled_v > (ACC_W+2)'(255)) ? '1 : scaled_v[PIX_W-1:0];
    end

    // Stage 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else if (s2_en) begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/conv_pool_multi.sv
// rtl/conv_pool_multi.sv - multi-kernel 4x4 tile conv/pool engine with start/busy/done control
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          one-cycle run request, honoured only when idle
//   base_addr      first tile address
//   num_tiles      tile count, 0..2^ADDR_W
//   pool_mode      0 = max, 1 = average
//   shift          right shift applied after ReLU
//   kernel_en      per-kernel write mask
//   conv_kernels   NUM_K packed 3x3 int8 kernels
//   input_re       image memory read enable
//   input_addr     image read address
//   image_4x4      tile data, valid the cycle after input_re
//   output_we      per-kernel result write enable
//   output_addr    result address (same as the tile's read address)
//   y              NUM_K result bytes
//   busy           run in progress
//   done           one-cycle completion pulse
module conv_pool_multi
    import conv_pool_pkg::*;
#(
    parameter int NUM_K   = 3,
    parameter int ADDR_W  = 16,
    parameter int SHIFT_W = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [ADDR_W:0]                 num_tiles,
    input  logic                            pool_mode,
    input  logic [SHIFT_W-1:0]              shift,
    input  logic [NUM_K-1:0]                kernel_en,
    input  logic [NUM_K*KER_TAPS*PIX_W-1:0] conv_kernels,
    output logic                            input_re,
    output logic [ADDR_W-1:0]               input_addr,
    input  logic [TILE_PIX*PIX_W-1:0]       image_4x4,
    output logic [NUM_K-1:0]                output_we,
    output logic [ADDR_W-1:0]               output_addr,
    output logic [NUM_K*PIX_W-1:0]          y,
    output logic                            busy,
    output logic                            done
);

    localparam int KER_BITS = KER_TAPS * PIX_W;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [ADDR_W:0] ONE_TILE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]                state_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W:0]           rem_q;
    logic                      mode_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic [NUM_K-1:0]          en_q;
    logic [NUM_K*KER_BITS-1:0] kern_q;

    // v1: image data on the bus, v2: conv sums registered, v3: result bytes registered
    logic                      v1_q, v2_q, v3_q;
    logic [ADDR_W-1:0]         a1_q, a2_q, out_addr_q;

    assign input_re    = (state_q == ST_RUN);
    assign input_addr  = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign output_we   = {NUM_K{v3_q}} & en_q;
    assign output_addr = out_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            shift_q <= '0;
            en_q    <= '0;
            kern_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_tiles != '0) begin
                            addr_q  <= base_addr;
                            rem_q   <= num_tiles;
                            mode_q  <= pool_mode;
                            shift_q <= shift;
                            en_q    <= kernel_en;
                            kern_q  <= conv_kernels;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr_q <= addr_q + 1'b1;
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == ONE_TILE) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only the final result stage may still be occupied, so
                    // DONE lands the cycle after the last write.
                    if (!v1_q && !v2_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            a1_q       <= '0;
            a2_q       <= '0;
            out_addr_q <= '0;
        end else begin
            v1_q <= input_re;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (input_re) begin
                a1_q <= input_addr;
            end
            if (v1_q) begin
                a2_q <= a1_q;
            end
            if (v2_q) begin
                out_addr_q <= a2_q;
            end
        end
    end

    for (genvar k = 0; k < NUM_K; k++) begin : g_lane
        conv_pool_lane #(
            .SHIFT_W(SHIFT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en    (v1_q),
            .tile     (image_4x4),
            .kern     (kern_q[KER_BITS*k +: KER_BITS]),
            .s2_en    (v2_q),
            .pool_mode(mode_q),
            .shift    (shift_q),
            .y        (y[PIX_W*k +: PIX_W])
        );
    end

endmodule

// File: tb/tb_conv_pool_multi.sv
// tb/tb_conv_pool_multi.sv - self-checking bench for conv_pool_multi
module tb_conv_pool_multi;

    localparam int NUM_K   = 3;
    localparam int ADDR_W  = 16;
    localparam int SHIFT_W = 3;

    logic                  clk_tb = 1'b0;
    logic                  rst_n  = 1'b0;
    logic                  start  = 1'b0;
    logic [ADDR_W-1:0]     base_addr = '0;
    logic [ADDR_W:0]       num_tiles = '0;
    logic                  pool_mode = 1'b0;
    logic [SHIFT_W-1:0]    shift = '0;
    logic [NUM_K-1:0]      kernel_en = '0;
    logic [NUM_K*72-1:0]   conv_kernels = '0;
    logic                  input_re;
    logic [ADDR_W-1:0]     input_addr;
    logic [127:0]          image_4x4 = '0;
    logic [NUM_K-1:0]      output_we;
    logic [ADDR_W-1:0]     output_addr;
    logic [NUM_K*8-1:0]    y;
    logic                  busy;
    logic                  done;

    int n_checks = 0;
    int n_errors = 0;

    conv_pool_multi #(
        .NUM_K(NUM_K), .ADDR_W(ADDR_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk_tb), .rst(rst_n), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .pool_mode(pool_mode), .shift(shift),
        .kernel_en(kernel_en), .conv_kernels(conv_kernels),
        .input_re(input_re), .input_addr(input_addr), .image_4x4(image_4x4),
        .output_we(output_we), .output_addr(output_addr), .y(y),
        .busy(busy), .done(done)
    );

    always #5 clk_tb = ~clk_tb;

    // Image memory: 64 tiles, aliased on the low address bits.
    logic [127:0] tile_mem [64];
    always @(posedge clk_tb) begin
        if (input_re) image_4x4 <= tile_mem[input_addr[5:0]];
    end

    // Observations of one run.
    int          rd_cyc [$];
    logic [15:0] rd_addr[$];
    int          wr_cyc [$];
    logic [15:0] wr_addr[$];
    logic [2:0]  wr_we  [$];
    logic [23:0] wr_y   [$];
    int          done_cyc, done_cnt, busy_err;
    logic        busy_after;

    // Reference: direct arithmetic from the definition of conv, pool, ReLU,
    // shift and saturation.
    function automatic logic [7:0] model_y(input logic [127:0] t, input logic [71:0] kw,
                                           input logic mode, input logic [2:0] sh);
        int c[4];
        int pool, v;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                c[2*a+b] = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        c[2*a+b] += int'(t[8*(4*(a+i)+(b+j)) +: 8]) * int'($signed(kw[8*(3*i+j) +: 8]));
                    end
                end
            end
        end
        if (mode) begin
            pool = (c[0] + c[1] + c[2] + c[3]) >>> 2;
        end else begin
            pool = c[0];
            for (int o = 1; o < 4; o++) if (c[o] > pool) pool = c[o];
        end
        v = (pool < 0) ? 0 : pool;
        v = v >> sh;
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    function automatic logic [23:0] exp_word(input logic [15:0] addr, input logic [215:0] kern,
                                             input logic mode, input logic [2:0] sh);
        logic [23:0] r;
        for (int q = 0; q < 3; q++) r[8*q +: 8] = model_y(tile_mem[addr[5:0]], kern[72*q +: 72], mode, sh);
        return r;
    endfunction

    function automatic logic [215:0] rand_kern();
        logic [215:0] k;
        for (int b = 0; b < 27; b++) k[8*b +: 8] = 8'($urandom);
        return k;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 64; i++) tile_mem[i] = {16{v}};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++)
            for (int w = 0; w < 4; w++) tile_mem[i][32*w +: 32] = $urandom;
    endtask

    // Launch one run and record reads, writes, done and busy until a few
    // cycles past done or until the cycle budget runs out. Cycle 1 is the
    // cycle after the edge that samples start. A second start with scrambled
    // ports is issued at cycle mid_cycle (0 = never).
    task automatic do_run(input logic [15:0] base, input logic [16:0] n, input logic mode,
                          input logic [2:0] sh, input logic [2:0] en, input logic [215:0] kern,
                          input int mid_cycle);
        int limit;
        rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete();
        wr_addr.delete(); wr_we.delete(); wr_y.delete();
        done_cyc = -1; done_cnt = 0; busy_err = 0; busy_after = 1'b1;
        limit = int'(n) + 16;
        @(negedge clk_tb);
        base_addr = base; num_tiles = n; pool_mode = mode; shift = sh;
        kernel_en = en; conv_kernels = kern; start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (input_re) begin rd_cyc.push_back(c); rd_addr.push_back(input_addr); end
            if (output_we != '0) begin
                wr_cyc.push_back(c); wr_addr.push_back(output_addr);
                wr_we.push_back(output_we); wr_y.push_back(y);
            end
            if (done_cyc < 0 && busy !== 1'b1) busy_err++;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            start = (c == mid_cycle);
            if (c == mid_cycle) begin
                base_addr = 16'($urandom); num_tiles = 17'($urandom_range(0, 20));
                pool_mode = ~mode; shift = ~sh; kernel_en = ~en; conv_kernels = rand_kern();
            end
            @(negedge clk_tb);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_tb);
        n_checks++; if (input_re !== 1'b0) begin n_errors++; $display("FAIL reset_input_re: got %0b expected 0", input_re); end
        n_checks++; if (input_addr !== '0) begin n_errors++; $display("FAIL reset_input_addr: got %0h expected 0", input_addr); end
        n_checks++; if (output_we !== '0) begin n_errors++; $display("FAIL reset_output_we: got %0b expected 0", output_we); end
        n_checks++; if (output_addr !== '0) begin n_errors++; $display("FAIL reset_output_addr: got %0h expected 0", output_addr); end
        n_checks++; if (y !== '0) begin n_errors++; $display("FAIL reset_y: got %0h expected 0", y); end
        n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL reset_busy_done: got %0b expected 00", {busy, done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_tb);
        n_checks++; if ({input_re, busy, done} !== 3'b000) begin n_errors++; $display("FAIL reset_idle: got %0b expected 000", {input_re, busy, done}); end
    endtask

    task automatic test_identity();
        logic [71:0] kid;
        kid = '0; kid[39:32] = 8'h01;
        fill_const(8'h0A);
        do_run(16'h0000, 17'd4, 1'b0, 3'd0, 3'b111, {kid, kid, kid}, 0);
        n_checks++; if (wr_cyc.size() !== 4) begin n_errors++; $display("FAIL ident_writes: got %0d expected 4", wr_cyc.size()); end
        n_checks++; if (rd_cyc.size() < 1 || rd_cyc[0] !== 1) begin n_errors++; $display("FAIL ident_first_re: got %0d reads expected first at cycle 1", rd_cyc.size()); end
        if (wr_cyc.size() == 4 && rd_cyc.size() == 4) begin
            n_checks++; if (wr_cyc[0] !== rd_cyc[0] + 3) begin n_errors++; $display("FAIL ident_latency: got %0d expected %0d", wr_cyc[0], rd_cyc[0] + 3); end
            n_checks++; if (done_cyc !== wr_cyc[3] + 1) begin n_errors++; $display("FAIL ident_done_cyc: got %0d expected %0d", done_cyc, wr_cyc[3] + 1); end
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (wr_addr[k] !== 16'(k)) begin n_errors++; $display("FAIL ident_addr%0d: got %0h expected %0h", k, wr_addr[k], k); end
                n_checks++; if (wr_y[k] !== 24'h0A0A0A) begin n_errors++; $display("FAIL ident_y%0d: got %0h expected 0a0a0a", k, wr_y[k]); end
            end
        end
        n_checks++; if (busy_err !== 0) begin n_errors++; $display("FAIL ident_busy: got %0d low cycles expected 0", busy_err); end
        n_checks++; if (busy_after !== 1'b0) begin n_errors++; $display("FAIL ident_busy_after: got %0b expected 0", busy_after); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL ident_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_avg_sat();
        logic [215:0] ones;
        ones = {27{8'h01}};
        fill_const(8'd200);
        do_run(16'h0010, 17'd2, 1'b1, 3'd3, 3'b111, ones, 0);
        n_checks++; if (wr_y.size() !== 2) begin n_errors++; $display("FAIL avg_writes: got %0d expected 2", wr_y.size()); end
        for (int k = 0; k < wr_y.size(); k++) begin
            n_checks++; if (wr_y[k] !== 24'hE1E1E1) begin n_errors++; $display("FAIL avg_y%0d: got %0h expected e1e1e1", k, wr_y[k]); end
        end
        do_run(16'h0020, 17'd2, 1'b1, 3'd0, 3'b111, ones, 0);
        n_checks++; if (wr_y.size() !== 2) begin n_errors++; $display("FAIL sat_writes: got %0d expected 2", wr_y.size()); end
        for (int k = 0; k < wr_y.size(); k++) begin
            n_checks++; if (wr_y[k] !== 24'hFFFFFF) begin n_errors++; $display("FAIL sat_y%0d: got %0h expected ffffff", k, wr_y[k]); end
        end
    endtask

    task automatic test_mask();
        fill_const(8'd50);
        do_run(16'h0100, 17'd3, 1'b0, 3'd0, 3'b101, {27{8'hFF}}, 0);
        n_checks++; if (wr_we.size() !== 3) begin n_errors++; $display("FAIL mask_writes: got %0d expected 3", wr_we.size()); end
        for (int k = 0; k < wr_we.size(); k++) begin
            n_checks++; if (wr_we[k] !== 3'b101) begin n_errors++; $display("FAIL mask_we%0d: got %0b expected 101", k, wr_we[k]); end
            n_checks++; if ({wr_y[k][23:16], wr_y[k][7:0]} !== 16'h0000) begin n_errors++; $display("FAIL mask_y%0d: got %0h expected y0=y2=0", k, wr_y[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [215:0] kern;
        logic [15:0]  exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        fill_rand();
        kern = rand_kern();
        do_run(16'hFFFE, 17'd4, 1'b1, 3'd1, 3'b111, kern, 0);
        n_checks++; if (rd_addr.size() !== 4 || wr_addr.size() !== 4) begin n_errors++; $display("FAIL wrap_counts: got %0d reads %0d writes expected 4 and 4", rd_addr.size(), wr_addr.size()); end
        for (int k = 0; k < 4 && k < rd_addr.size() && k < wr_addr.size(); k++) begin
            n_checks++; if (rd_addr[k] !== exp_a[k]) begin n_errors++; $display("FAIL wrap_rd%0d: got %0h expected %0h", k, rd_addr[k], exp_a[k]); end
            n_checks++; if (wr_addr[k] !== exp_a[k]) begin n_errors++; $display("FAIL wrap_wr%0d: got %0h expected %0h", k, wr_addr[k], exp_a[k]); end
            n_checks++; if (wr_y[k] !== exp_word(exp_a[k], kern, 1'b1, 3'd1)) begin n_errors++; $display("FAIL wrap_y%0d: got %0h expected %0h", k, wr_y[k], exp_word(exp_a[k], kern, 1'b1, 3'd1)); end
        end
    endtask

    task automatic test_zero_tiles();
        do_run(16'h1234, 17'd0, 1'b0, 3'd0, 3'b111, rand_kern(), 0);
        n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
        n_checks++; if (rd_cyc.size() !== 0 || wr_cyc.size() !== 0) begin n_errors++; $display("FAIL zero_activity: got %0d reads %0d writes expected 0 and 0", rd_cyc.size(), wr_cyc.size()); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_busy_ignore();
        logic [215:0] kern;
        logic [15:0]  base, ea;
        fill_rand();
        kern = rand_kern();
        base = 16'($urandom);
        do_run(base, 17'd10, 1'b0, 3'd2, 3'b111, kern, 3);
        n_checks++; if (wr_cyc.size() !== 10) begin n_errors++; $display("FAIL busy_writes: got %0d expected 10", wr_cyc.size()); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt); end
        for (int k = 0; k < wr_cyc.size() && k < 10; k++) begin
            ea = base + 16'(k);
            n_checks++; if (wr_addr[k] !== ea || wr_we[k] !== 3'b111) begin n_errors++; $display("FAIL busy_wr%0d: got addr %0h we %0b expected %0h 111", k, wr_addr[k], wr_we[k], ea); end
            n_checks++; if (wr_y[k] !== exp_word(ea, kern, 1'b0, 3'd2)) begin n_errors++; $display("FAIL busy_y%0d: got %0h expected %0h", k, wr_y[k], exp_word(ea, kern, 1'b0, 3'd2)); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [215:0] kern;
        logic [15:0]  base2;
        int           act;
        fill_rand();
        kern = rand_kern();
        @(negedge clk_tb);
        base_addr = 16'h0200; num_tiles = 17'd10; pool_mode = 1'b0; shift = 3'd0;
        kernel_en = 3'b111; conv_kernels = kern; start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        repeat (5) @(negedge clk_tb);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({input_re, output_we, busy, done} !== 6'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got %0b expected 0", {input_re, output_we, busy, done}); end
        n_checks++; if ({input_addr, output_addr, y} !== '0) begin n_errors++; $display("FAIL rstmid_data: got %0h expected 0", {input_addr, output_addr, y}); end
        repeat (2) @(negedge clk_tb);
        rst_n = 1'b1;
        act = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_tb);
            if (input_re || output_we != '0 || done || busy) act++;
        end
        n_checks++; if (act !== 0) begin n_errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", act); end
        base2 = 16'($urandom);
        do_run(base2, 17'd5, 1'b1, 3'd0, 3'b111, kern, 0);
        n_checks++; if (rd_addr.size() < 1 || rd_addr[0] !== base2) begin n_errors++; $display("FAIL rstmid_restart_addr: got %0d reads expected first at %0h", rd_addr.size(), base2); end
        n_checks++; if (wr_cyc.size() !== 5 || done_cnt !== 1) begin n_errors++; $display("FAIL rstmid_restart: got %0d writes %0d done expected 5 and 1", wr_cyc.size(), done_cnt); end
        if (wr_y.size() > 0) begin
            n_checks++; if (wr_y[0] !== exp_word(base2, kern, 1'b1, 3'd0)) begin n_errors++; $display("FAIL rstmid_y0: got %0h expected %0h", wr_y[0], exp_word(base2, kern, 1'b1, 3'd0)); end
        end
    endtask

    // Back-to-back random runs with random config, checked tile by tile.
    task automatic test_random();
        logic [215:0] kern;
        logic [15:0]  base, ea;
        logic [2:0]   sh, en;
        logic         mode;
        int           n;
        for (int r = 0; r < 8; r++) begin
            fill_rand();
            kern = rand_kern();
            base = 16'($urandom);
            n    = $urandom_range(1, 12);
            mode = 1'($urandom);
            sh   = 3'($urandom);
            en   = 3'($urandom_range(1, 7));
            do_run(base, 17'(n), mode, sh, en, kern, 0);
            n_checks++; if (wr_cyc.size() !== n || rd_cyc.size() !== n) begin n_errors++; $display("FAIL rnd%0d_counts: got %0d reads %0d writes expected %0d", r, rd_cyc.size(), wr_cyc.size(), n); end
            if (wr_cyc.size() > 0) begin
                n_checks++; if (done_cyc !== wr_cyc[wr_cyc.size()-1] + 1) begin n_errors++; $display("FAIL rnd%0d_done: got %0d expected %0d", r, done_cyc, wr_cyc[wr_cyc.size()-1] + 1); end
            end
            n_checks++; if (busy_err !== 0 || busy_after !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_busy: got %0d low cycles, after %0b expected 0 and 0", r, busy_err, busy_after); end
            for (int k = 0; k < n && k < wr_cyc.size() && k < rd_cyc.size(); k++) begin
                ea = base + 16'(k);
                n_checks++; if (rd_cyc[k] !== k + 1 || rd_addr[k] !== ea) begin n_errors++; $display("FAIL rnd%0d_rd%0d: got cyc %0d addr %0h expected %0d %0h", r, k, rd_cyc[k], rd_addr[k], k + 1, ea); end
                n_checks++; if (wr_cyc[k] !== rd_cyc[k] + 3 || wr_addr[k] !== ea || wr_we[k] !== en) begin n_errors++; $display("FAIL rnd%0d_wr%0d: got cyc %0d addr %0h we %0b expected %0d %0h %0b", r, k, wr_cyc[k], wr_addr[k], wr_we[k], rd_cyc[k] + 3, ea, en); end
                n_checks++; if (wr_y[k] !== exp_word(ea, kern, mode, sh)) begin n_errors++; $display("FAIL rnd%0d_y%0d: got %0h expected %0h", r, k, wr_y[k], exp_word(ea, kern, mode, sh)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_avg_sat();
        test_mask();
        test_wrap();
        test_zero_tiles();
        test_busy_ignore();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
